// File: rtl/prefetch_ar_arbiter_pkg.sv
//==============================================================================
// Module  : prefetch_arb_pkg
// Brief   : Shared types and round-robin helper for the prefetch AR arbiter.
// Rev     : 1.0 - initial release
//==============================================================================
`default_nettype none

package prefetch_arb_pkg;

    typedef enum logic [0:0] {
        ARB_IDLE  = 1'b0,
        ARB_ISSUE = 1'b1
    } arb_state_t;

    // Widest requester vector the helper accepts; callers zero-extend into it.
    localparam int MAX_REQ = 32;

    // First asserted valid starting at ptr and wrapping modulo num.
    // Returns ptr unchanged when nothing is valid.
    function automatic int rr_pick(input logic [MAX_REQ-1:0] valid,
                                   input int                ptr,
                                   input int                num);
        int result;
        int idx;
        result = ptr;
        for (int k = MAX_REQ - 1; k >= 0; k--) begin
            if (k < num) begin
                idx = (ptr + k) % num;
                if (valid[idx]) begin
                    result = idx;
                end
            end
        end
        return result;
    endfunction

endpackage

`default_nettype wire

// File: rtl/prefetch_ar_arbiter_if.sv
//==============================================================================
// Module  : prefetch_ar_arbiter_if
// Brief   : Requester-side and RAM-side AR/R signals of the prefetch arbiter.
// Rev     : 1.0 - initial release
//==============================================================================
`default_nettype none

interface prefetch_ar_arbiter_if #(
    parameter int NUM_REQ              = 2,
    parameter int ADDR_BITS            = 32,
    parameter int BURST_LEN_WIDTH      = 8,
    parameter int TID_WIDTH            = 8,
    parameter int LOG_BLOCK_DATA_BYTES = 0,
    parameter int LOG_OUTSTANDING      = 2
);
    localparam int DATA_WIDTH = 8 << LOG_BLOCK_DATA_BYTES;

    logic [NUM_REQ-1:0]                 req_ar_valid;
    logic [NUM_REQ-1:0]                 req_ar_ready;
    logic [NUM_REQ*ADDR_BITS-1:0]       req_ar_addr;
    logic [NUM_REQ*BURST_LEN_WIDTH-1:0] req_ar_len;
    logic [NUM_REQ*TID_WIDTH-1:0]       req_ar_id;
    logic [NUM_REQ-1:0]                 req_r_valid;
    logic [NUM_REQ-1:0]                 req_r_ready;
    logic [DATA_WIDTH-1:0]              req_r_data;
    logic                               req_r_last;
    logic [TID_WIDTH-1:0]               req_r_id;

    logic                               mem_ar_valid;
    logic                               mem_ar_ready;
    logic [ADDR_BITS-1:0]               mem_ar_addr;
    logic [BURST_LEN_WIDTH-1:0]         mem_ar_len;
    logic [TID_WIDTH-1:0]               mem_ar_id;
    logic                               mem_r_valid;
    logic                               mem_r_ready;
    logic [DATA_WIDTH-1:0]              mem_r_data;
    logic                               mem_r_last;
    logic [TID_WIDTH-1:0]               mem_r_id;

    logic [LOG_OUTSTANDING:0]           outstanding;
    logic                               err_orphan_r;

    modport slave (
        input  req_ar_valid, req_ar_addr, req_ar_len, req_ar_id, req_r_ready,
        input  mem_ar_ready, mem_r_valid, mem_r_data, mem_r_last, mem_r_id,
        output req_ar_ready, req_r_valid, req_r_data, req_r_last, req_r_id,
        output mem_ar_valid, mem_ar_addr, mem_ar_len, mem_ar_id, mem_r_ready,
        output outstanding, err_orphan_r
    );

    modport master (
        output req_ar_valid, req_ar_addr, req_ar_len, req_ar_id, req_r_ready,
        output mem_ar_ready, mem_r_valid, mem_r_data, mem_r_last, mem_r_id,
        input  req_ar_ready, req_r_valid, req_r_data, req_r_last, req_r_id,
        input  mem_ar_valid, mem_ar_addr, mem_ar_len, mem_ar_id, mem_r_ready,
        input  outstanding, err_orphan_r
    );

endinterface

`default_nettype wire

// File: rtl/prefetch_ar_arbiter_route_fifo.sv
//==============================================================================
// Module  : arb_route_fifo
// Brief   : Synchronous FIFO of granted requester indices, one entry per burst.
// Rev     : 1.0 - initial release
//==============================================================================
`default_nettype none

module arb_route_fifo #(
    parameter int WIDTH     = 1,
    parameter int LOG_DEPTH = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 push,
    input  logic [WIDTH-1:0]     push_data,
    input  logic                 pop,
    output logic [WIDTH-1:0]     head,
    output logic                 full,
    output logic                 empty,
    output logic [LOG_DEPTH:0]   count
);
    localparam int DEPTH = 1 << LOG_DEPTH;

    logic [WIDTH-1:0]     mem [DEPTH];
    logic [LOG_DEPTH-1:0] wr_ptr;
    logic [LOG_DEPTH-1:0] rd_ptr;
    logic [LOG_DEPTH:0]   cnt;
    logic                 do_push;
    logic                 do_pop;

    assign full    = (cnt == (LOG_DEPTH+1)'(DEPTH));
    assign empty   = (cnt == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];
    assign count   = cnt;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + LOG_DEPTH'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + LOG_DEPTH'(1);
            end
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + (LOG_DEPTH+1)'(1);
                2'b01:   cnt <= cnt - (LOG_DEPTH+1)'(1);
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/prefetch_ar_arbiter.sv
//==============================================================================
// Module  : prefetch_ar_arbiter
// Brief   : Round-robin AR arbiter with in-order R steering for prefetchers.
// Rev     : 1.0 - initial release
//==============================================================================
`default_nettype none

module prefetch_ar_arbiter
    import prefetch_arb_pkg::*;
#(
    parameter int NUM_REQ              = 2,
    parameter int ADDR_BITS            = 32,
    parameter int BURST_LEN_WIDTH      = 8,
    parameter int TID_WIDTH            = 8,
    parameter int LOG_BLOCK_DATA_BYTES = 0,
    parameter int LOG_OUTSTANDING      = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    prefetch_ar_arbiter_if.slave bus
);
    localparam int IDX_W = $clog2(NUM_REQ);

    logic [ADDR_BITS-1:0]       addr_arr [NUM_REQ];
    logic [BURST_LEN_WIDTH-1:0] len_arr  [NUM_REQ];
    logic [TID_WIDTH-1:0]       id_arr   [NUM_REQ];

    arb_state_t                 state;
    logic [IDX_W-1:0]           rr_ptr;
    logic [ADDR_BITS-1:0]       issue_addr;
    logic [BURST_LEN_WIDTH-1:0] issue_len;
    logic [TID_WIDTH-1:0]       issue_id;
    logic                       orphan_err;

    logic [MAX_REQ-1:0]         valid_ext;
    logic [IDX_W-1:0]           winner;
    logic [IDX_W-1:0]           next_ptr;
    logic                       accept;
    logic [NUM_REQ-1:0]         ar_ready;
    logic [NUM_REQ-1:0]         r_valid;
    logic                       r_ready;
    logic                       pop;
    logic                       fifo_full;
    logic                       fifo_empty;
    logic [IDX_W-1:0]           head;
    logic [LOG_OUTSTANDING:0]   fifo_count;

    // Requester 0 occupies the most significant slice of each packed bus.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign addr_arr[gi] = bus.req_ar_addr[(NUM_REQ-1-gi)*ADDR_BITS +: ADDR_BITS];
            assign len_arr[gi]  = bus.req_ar_len[(NUM_REQ-1-gi)*BURST_LEN_WIDTH +: BURST_LEN_WIDTH];
            assign id_arr[gi]   = bus.req_ar_id[(NUM_REQ-1-gi)*TID_WIDTH +: TID_WIDTH];
        end
    endgenerate

    assign valid_ext = MAX_REQ'(bus.req_ar_valid);
    assign winner    = IDX_W'(rr_pick(valid_ext, int'(rr_ptr), NUM_REQ));
    assign next_ptr  = IDX_W'((int'(winner) + 1) % NUM_REQ);
    assign accept    = !rst && (state == ARB_IDLE) && (|bus.req_ar_valid) && !fifo_full;

    always_comb begin
        ar_ready = '0;
        if (accept) begin
            ar_ready[winner] = 1'b1;
        end
    end

    // An empty route FIFO swallows stray beats so the RAM cannot wedge.
    always_comb begin
        r_valid = '0;
        r_ready = !rst;
        if (!fifo_empty) begin
            r_valid[head] = bus.mem_r_valid;
            r_ready       = bus.req_r_ready[head];
        end
    end

    assign pop = !fifo_empty && bus.mem_r_valid && r_ready && bus.mem_r_last;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ARB_IDLE;
            rr_ptr     <= '0;
            issue_addr <= '0;
            issue_len  <= '0;
            issue_id   <= '0;
            orphan_err <= 1'b0;
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (accept) begin
                        issue_addr <= addr_arr[winner];
                        issue_len  <= len_arr[winner];
                        issue_id   <= id_arr[winner];
                        rr_ptr     <= next_ptr;
                        state      <= ARB_ISSUE;
                    end
                end
                ARB_ISSUE: begin
                    if (bus.mem_ar_ready) begin
                        state <= ARB_IDLE;
                    end
                end
                default: state <= ARB_IDLE;
            endcase
            if (fifo_empty && bus.mem_r_valid) begin
                orphan_err <= 1'b1;
            end
        end
    end

    arb_route_fifo #(
        .WIDTH     (IDX_W),
        .LOG_DEPTH (LOG_OUTSTANDING)
    ) u_route_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (accept),
        .push_data (winner),
        .pop       (pop),
        .head      (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign bus.req_ar_ready = ar_ready;
    assign bus.mem_ar_valid = (state == ARB_ISSUE);
    assign bus.mem_ar_addr  = issue_addr;
    assign bus.mem_ar_len   = issue_len;
    assign bus.mem_ar_id    = issue_id;
    assign bus.req_r_valid  = r_valid;
    assign bus.mem_r_ready  = r_ready;
    assign bus.req_r_data   = bus.mem_r_data;
    assign bus.req_r_last   = bus.mem_r_last;
    assign bus.req_r_id     = bus.mem_r_id;
    assign bus.outstanding  = fifo_count;
    assign bus.err_orphan_r = orphan_err;

endmodule

`default_nettype wire

// File: tb/tb_prefetch_ar_arbiter.sv
//==============================================================================
// Module  : tb_prefetch_ar_arbiter
// Brief   : Self-checking bench: behavioural arbiter/route model plus RAM model.
// Rev     : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_prefetch_ar_arbiter;

    localparam int NUM_REQ  = 2;
    localparam int ADDR_B   = 32;
    localparam int LEN_W    = 8;
    localparam int TID_W    = 8;
    localparam int LOG_BDB  = 0;
    localparam int LOG_OUT  = 2;
    localparam int DW       = 8 << LOG_BDB;
    localparam int DEPTH    = 1 << LOG_OUT;

    typedef struct {
        int               req;
        logic [ADDR_B-1:0] addr;
        logic [LEN_W-1:0]  len;
        logic [TID_W-1:0]  id;
    } burst_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    prefetch_ar_arbiter_if #(
        .NUM_REQ(NUM_REQ), .ADDR_BITS(ADDR_B), .BURST_LEN_WIDTH(LEN_W),
        .TID_WIDTH(TID_W), .LOG_BLOCK_DATA_BYTES(LOG_BDB), .LOG_OUTSTANDING(LOG_OUT)
    ) bus ();

    prefetch_ar_arbiter #(
        .NUM_REQ(NUM_REQ), .ADDR_BITS(ADDR_B), .BURST_LEN_WIDTH(LEN_W),
        .TID_WIDTH(TID_W), .LOG_BLOCK_DATA_BYTES(LOG_BDB), .LOG_OUTSTANDING(LOG_OUT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference state: what each requester still wants to send, the ordered
    // list of granted bursts awaiting R data, and the RAM's own burst queue.
    burst_t src_q [NUM_REQ][$];
    burst_t route_q[$];
    burst_t ram_q[$];
    int     grants[$];
    burst_t pend;
    bit     pending;
    bit     err_m;
    int     rr;
    int     beat_m;
    int     ram_beat;
    bit     ram_rvalid;
    bit     orphan_now;
    bit     ar_en;
    bit     r_en;
    int     ar_pct;
    int     rmode;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] data_of(input logic [ADDR_B-1:0] a, input int b);
        logic [7:0] t;
        t = a[7:0] ^ 8'(b * 29 + 17);
        return DW'(t);
    endfunction

    function automatic burst_t mk(input logic [ADDR_B-1:0] a, input int l, input int id);
        burst_t b;
        b.req  = 0;
        b.addr = a;
        b.len  = LEN_W'(l);
        b.id   = TID_W'(id);
        return b;
    endfunction

    function automatic bit is_idle();
        for (int i = 0; i < NUM_REQ; i++) if (src_q[i].size() != 0) return 1'b0;
        return !pending && route_q.size() == 0 && ram_q.size() == 0 && !ram_rvalid;
    endfunction

    task automatic drive();
        logic [NUM_REQ-1:0]       v;
        logic [NUM_REQ*ADDR_B-1:0] a;
        logic [NUM_REQ*LEN_W-1:0]  l;
        logic [NUM_REQ*TID_W-1:0]  d;
        v = '0; a = '0; l = '0; d = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (src_q[i].size() > 0) begin
                v[i] = 1'b1;
                a[(NUM_REQ-1-i)*ADDR_B +: ADDR_B] = src_q[i][0].addr;
                l[(NUM_REQ-1-i)*LEN_W  +: LEN_W]  = src_q[i][0].len;
                d[(NUM_REQ-1-i)*TID_W  +: TID_W]  = src_q[i][0].id;
            end
        end
        bus.req_ar_valid = v;
        bus.req_ar_addr  = a;
        bus.req_ar_len   = l;
        bus.req_ar_id    = d;
        bus.mem_ar_ready = ar_en && ($urandom_range(99) < ar_pct);
        if (orphan_now) begin
            bus.mem_r_valid = 1'b1;
            bus.mem_r_data  = DW'($urandom);
            bus.mem_r_last  = 1'b1;
            bus.mem_r_id    = TID_W'($urandom);
        end else if (!ram_rvalid) begin
            bus.mem_r_valid = 1'b0;
            if (r_en && ram_q.size() > 0 && $urandom_range(3) != 0) begin
                ram_rvalid      = 1'b1;
                bus.mem_r_valid = 1'b1;
                bus.mem_r_data  = data_of(ram_q[0].addr, ram_beat);
                bus.mem_r_last  = (ram_beat == int'(ram_q[0].len));
                bus.mem_r_id    = ram_q[0].id;
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            bus.req_r_ready[i] = (rmode == 1) ? 1'b1 : (rmode == 2) ? 1'b0 : ($urandom_range(3) != 0);
        end
    endtask

    // One clock: drive at posedge+1, compare at the falling edge, then
    // advance the reference and the RAM as the next rising edge will.
    task automatic step();
        logic [NUM_REQ-1:0] v, exp_rdy, exp_rv;
        int     w;
        bit     acc, rh;
        burst_t b;
        drive();
        #4;
        v = bus.req_ar_valid;
        w = -1; acc = 1'b0; exp_rdy = '0;
        if (!pending && v != '0 && route_q.size() < DEPTH) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                if (w < 0 && v[(rr + k) % NUM_REQ]) w = (rr + k) % NUM_REQ;
            end
            acc = 1'b1;
            exp_rdy[w] = 1'b1;
        end
        check_eq("req_ar_ready", 64'(bus.req_ar_ready), 64'(exp_rdy));
        check_eq("mem_ar_valid", 64'(bus.mem_ar_valid), 64'(pending));
        if (pending) begin
            check_eq("mem_ar_addr", 64'(bus.mem_ar_addr), 64'(pend.addr));
            check_eq("mem_ar_len",  64'(bus.mem_ar_len),  64'(pend.len));
            check_eq("mem_ar_id",   64'(bus.mem_ar_id),   64'(pend.id));
        end
        check_eq("outstanding",  64'(bus.outstanding),  64'(route_q.size()));
        check_eq("err_orphan_r", 64'(bus.err_orphan_r), 64'(err_m));
        rh = 1'b0; exp_rv = '0;
        if (route_q.size() > 0) begin
            if (bus.mem_r_valid) exp_rv[route_q[0].req] = 1'b1;
            check_eq("req_r_valid", 64'(bus.req_r_valid), 64'(exp_rv));
            check_eq("mem_r_ready", 64'(bus.mem_r_ready), 64'(bus.req_r_ready[route_q[0].req]));
            if (bus.mem_r_valid) begin
                check_eq("req_r_id",   64'(bus.req_r_id),   64'(route_q[0].id));
                check_eq("req_r_data", 64'(bus.req_r_data), 64'(data_of(route_q[0].addr, beat_m)));
                check_eq("req_r_last", 64'(bus.req_r_last), 64'(beat_m == int'(route_q[0].len)));
                rh = bus.req_r_ready[route_q[0].req];
            end
        end else if (bus.mem_r_valid) begin
            check_eq("orphan_r_valid", 64'(bus.req_r_valid), 64'(0));
            check_eq("orphan_r_ready", 64'(bus.mem_r_ready), 64'(1));
            err_m = 1'b1;
        end
        // reference update: pop reads the old head before any push
        if (rh) begin
            if (beat_m == int'(route_q[0].len)) begin
                void'(route_q.pop_front());
                beat_m = 0;
            end else begin
                beat_m++;
            end
        end
        if (pending && bus.mem_ar_ready) pending = 1'b0;
        if (acc) begin
            pend     = src_q[w][0];
            pend.req = w;
            route_q.push_back(pend);
            pending  = 1'b1;
            rr       = (w + 1) % NUM_REQ;
            grants.push_back(w);
        end
        // environment update from what the DUT actually did
        for (int i = 0; i < NUM_REQ; i++) begin
            if (bus.req_ar_valid[i] && bus.req_ar_ready[i]) void'(src_q[i].pop_front());
        end
        if (bus.mem_ar_valid && bus.mem_ar_ready) begin
            b = mk(bus.mem_ar_addr, int'(bus.mem_ar_len), int'(bus.mem_ar_id));
            ram_q.push_back(b);
        end
        if (bus.mem_r_valid && bus.mem_r_ready) begin
            if (orphan_now) begin
                orphan_now = 1'b0;
            end else if (ram_rvalid) begin
                ram_rvalid = 1'b0;
                if (ram_beat == int'(ram_q[0].len)) begin
                    void'(ram_q.pop_front());
                    ram_beat = 0;
                end else begin
                    ram_beat++;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run_idle(input int budget);
        int n;
        n = 0;
        while (!is_idle() && n < budget) begin
            step();
            n++;
        end
        if (!is_idle()) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain_timeout: still busy after %0d cycles, required idle", budget);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        for (int i = 0; i < NUM_REQ; i++) src_q[i].delete();
        route_q.delete(); ram_q.delete();
        pending = 1'b0; err_m = 1'b0; rr = 0; beat_m = 0;
        ram_beat = 0; ram_rvalid = 1'b0; orphan_now = 1'b0;
        bus.req_ar_valid = '1;
        bus.req_ar_addr  = '1;
        bus.req_ar_len   = '0;
        bus.req_ar_id    = '0;
        bus.req_r_ready  = '1;
        bus.mem_ar_ready = 1'b0;
        bus.mem_r_valid  = 1'b0;
        bus.mem_r_data   = '0;
        bus.mem_r_last   = 1'b0;
        bus.mem_r_id     = '0;
        for (int c = 0; c < 2; c++) begin
            @(posedge clk);
            #1;
            check_eq("rst_req_ar_ready", 64'(bus.req_ar_ready), 64'(0));
            check_eq("rst_mem_ar_valid", 64'(bus.mem_ar_valid), 64'(0));
            check_eq("rst_req_r_valid",  64'(bus.req_r_valid),  64'(0));
            check_eq("rst_mem_r_ready",  64'(bus.mem_r_ready),  64'(0));
            check_eq("rst_outstanding",  64'(bus.outstanding),  64'(0));
            check_eq("rst_err_orphan",   64'(bus.err_orphan_r), 64'(0));
        end
        rst = 1'b0;
        bus.req_ar_valid = '0;
    endtask

    initial begin
        ar_en = 1'b1; r_en = 1'b1; ar_pct = 100; rmode = 1;
        #1;
        do_reset();

        // single read from requester 0
        src_q[0].push_back(mk(32'hbeef, 0, 5));
        run_idle(50);
        check_eq("single_grant", 64'(grants.size() == 1 && grants[0] == 0), 64'(1));

        // round robin with both requesters continuously valid
        do_reset();
        grants.delete();
        for (int k = 0; k < 2; k++) begin
            src_q[0].push_back(mk(32'h1000 + 32'(k * 16), 1, 8'h10 + k));
            src_q[1].push_back(mk(32'h2000 + 32'(k * 16), 1, 8'h20 + k));
        end
        run_idle(200);
        check_eq("rr_count", 64'(grants.size()), 64'(4));
        for (int k = 0; k < 4 && k < grants.size(); k++) begin
            check_eq("rr_order", 64'(grants[k]), 64'(k % 2));
        end

        // AR backpressure, then R backpressure
        src_q[0].push_back(mk(32'h3000, 2, 3));
        src_q[1].push_back(mk(32'h4000, 1, 4));
        ar_en = 1'b0;
        repeat (6) step();
        ar_en = 1'b1;
        rmode = 2;
        repeat (15) step();
        rmode = 1;
        run_idle(200);

        // fill the route FIFO with R stalled
        r_en = 1'b0;
        for (int k = 0; k < 3; k++) src_q[0].push_back(mk(32'h5000 + 32'(k * 64), 3, 8'h50 + k));
        for (int k = 0; k < 2; k++) src_q[1].push_back(mk(32'h6000 + 32'(k * 64), 3, 8'h60 + k));
        repeat (20) step();
        check_eq("full_outstanding", 64'(bus.outstanding), 64'(4));
        check_eq("full_no_ready",    64'(bus.req_ar_ready), 64'(0));
        check_eq("full_left_over",   64'(src_q[0].size() + src_q[1].size()), 64'(1));
        r_en = 1'b1;
        run_idle(400);

        // randomized traffic
        ar_pct = 60;
        rmode  = 0;
        for (int c = 0; c < 800; c++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (src_q[i].size() < 3 && $urandom_range(7) == 0) begin
                    src_q[i].push_back(mk(ADDR_B'($urandom), $urandom_range(3), $urandom_range(255)));
                end
            end
            step();
        end
        rmode = 1;
        run_idle(2000);

        // orphan beat with an empty route FIFO; flag stays set until reset
        orphan_now = 1'b1;
        step();
        repeat (4) step();
        src_q[1].push_back(mk(32'h7777, 1, 7));
        run_idle(100);
        check_eq("orphan_sticky", 64'(bus.err_orphan_r), 64'(1));
        do_reset();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
